// File: rtl/mem_port_arbiter.sv
// IF / LS arbiter for the single-ported unified memory, one outstanding txn.
// Optional perf counters enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic                ls_req_we,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_ls_grants,
  output logic [31:0]         perf_conflict_cycles
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic { IDLE, WAIT_RSP } state_t;
  typedef enum logic { OWN_IF, OWN_LS } owner_t;

  state_t     state, state_nxt;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       idle, grant_if, grant_ls, fire;

  always_comb begin
    // outputs gated by rst so nothing leaks while reset is held
    idle          = rst && (state == IDLE);
    grant_if      = if_req_valid &&
                    (!ls_req_valid || starve_cnt == SMAX);
    grant_ls      = ls_req_valid && !grant_if;
    mem_req_valid = idle && (if_req_valid || ls_req_valid);
    mem_req_we    = 1'b0;
    mem_req_wstrb = '0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (grant_ls) begin
      mem_req_we    = ls_req_we;
      mem_req_wstrb = ls_req_wstrb;
      mem_req_addr  = ls_req_addr;
      mem_req_wdata = ls_req_wdata;
    end else if (grant_if) begin
      mem_req_addr  = if_req_addr;
    end
    if_req_ready = idle && grant_if && mem_req_ready;
    ls_req_ready = idle && grant_ls && mem_req_ready;
    fire         = mem_req_valid && mem_req_ready;
    state_nxt    = state;
    case (state)
      IDLE:     if (fire) state_nxt = WAIT_RSP;
      WAIT_RSP: if (mem_rsp_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      starve_cnt   <= '0;
      busy         <= 1'b0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_data  <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt == WAIT_RSP);
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (fire) owner <= grant_ls ? OWN_LS : OWN_IF;
      if (!if_req_valid || (fire && grant_if))
        starve_cnt <= '0;
      else if (fire && grant_ls && starve_cnt < SMAX)
        starve_cnt <= starve_cnt + 4'd1;
      if (state == WAIT_RSP && mem_rsp_valid) begin
        if (owner == OWN_LS) begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_data  <= mem_rsp_data;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rsp_data;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_grants       <= '0;
      perf_ls_grants       <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (fire && grant_if)
        perf_if_grants <= perf_if_grants + 32'd1;
      if (fire && grant_ls)
        perf_ls_grants <= perf_ls_grants + 32'd1;
      if (idle && if_req_valid && ls_req_valid)
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
    end
  end
`else
  assign perf_if_grants       = '0;
  assign perf_ls_grants       = '0;
  assign perf_conflict_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Perf expectations follow MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [3:0]  ls_req_wstrb;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy;
  logic [31:0] perf_if_grants;
  logic [31:0] perf_ls_grants;
  logic [31:0] perf_conflict_cycles;

  int n_cmp = 0;
  int n_err = 0;
  int e_if = 0;
  int e_ls = 0;
  int e_cf = 0;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid),
    .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid),
    .ls_req_we(ls_req_we),
    .ls_req_wstrb(ls_req_wstrb),
    .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata),
    .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .busy(busy),
    .perf_if_grants(perf_if_grants),
    .perf_ls_grants(perf_ls_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
    chk({tag, "_pif"}, perf_if_grants, PERF ? e_if : 0);
    chk({tag, "_pls"}, perf_ls_grants, PERF ? e_ls : 0);
    chk({tag, "_pcf"}, perf_conflict_cycles, PERF ? e_cf : 0);
  endtask

  task automatic clr_req();
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    ls_req_wstrb = '0;
    ls_req_addr  = '0;
    ls_req_wdata = '0;
  endtask

  task automatic rsp_on(input logic [31:0] d, input bit to_ls);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    if (to_ls) ls_q.push_back(d);
    else if_q.push_back(d);
  endtask

  // scoreboard: every pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (if_rsp_valid === 1'b1) begin
      if (if_q.size() == 0) chk("if_spurious", if_rsp_valid, 0);
      else chk("if_rsp_data", if_rsp_data, if_q.pop_front());
    end
    if (ls_rsp_valid === 1'b1) begin
      if (ls_q.size() == 0) chk("ls_spurious", ls_rsp_valid, 0);
      else chk("ls_rsp_data", ls_rsp_data, ls_q.pop_front());
    end
  end

  initial begin
    int st;
    bit gi;
    rst = 1'b0;
    clr_req();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    // 1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req_valid  = 1'($urandom);
      if_req_addr   = $urandom;
      ls_req_valid  = 1'($urandom);
      ls_req_we     = 1'($urandom);
      ls_req_addr   = $urandom;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data  = $urandom;
      #1;
      chk("rst_mreq", mem_req_valid, 0);
      chk("rst_ifrdy", if_req_ready, 0);
      chk("rst_lsrdy", ls_req_ready, 0);
      if (i > 0) begin
        chk("rst_busy", busy, 0);
        chk("rst_ifv", if_rsp_valid, 0);
        chk("rst_lsv", ls_rsp_valid, 0);
        chk("rst_ifd", if_rsp_data, 0);
        chk("rst_lsd", ls_rsp_data, 0);
        chk_perf("rst");
      end
    end
    @(negedge clk);
    clr_req();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    rst = 1'b1;

    // 2: IF only
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h100;
    #1;
    chk("t2_mv", mem_req_valid, 1);
    chk("t2_addr", mem_req_addr, 32'h100);
    chk("t2_we", mem_req_we, 0);
    chk("t2_ifrdy", if_req_ready, 1);
    chk("t2_lsrdy", ls_req_ready, 0);
    e_if++;
    @(negedge clk);
    clr_req();
    rsp_on(32'h13, 1'b0);
    #1;
    chk("t2_busy", busy, 1);
    chk("t2_mv_w", mem_req_valid, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("t2_busy0", busy, 0);
    chk("t2_ifv", if_rsp_valid, 1);

    // 3: simultaneous, LS first then IF
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h104;
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h2000;
    #1;
    chk("t3_addr0", mem_req_addr, 32'h2000);
    chk("t3_lsrdy", ls_req_ready, 1);
    chk("t3_ifrdy", if_req_ready, 0);
    e_cf++;
    e_ls++;
    @(negedge clk);
    ls_req_valid = 1'b0;
    rsp_on(32'hA5A5_0001, 1'b1);
    #1;
    chk("t3_mv_w", mem_req_valid, 0);
    chk("t3_ifrdy_w", if_req_ready, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("t3_addr1", mem_req_addr, 32'h104);
    chk("t3_ifrdy1", if_req_ready, 1);
    e_if++;
    @(negedge clk);
    clr_req();
    rsp_on(32'h33, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk_perf("t3");

    // 4: starvation pattern LS x4, IF, ...
    st = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if_req_valid  = 1'b1;
      if_req_addr   = 32'h400;
      ls_req_valid  = 1'b1;
      ls_req_addr   = 32'h3000;
      #1;
      gi = (st == 4);
      chk("t4_ifrdy", if_req_ready, gi);
      chk("t4_lsrdy", ls_req_ready, !gi);
      chk("t4_addr", mem_req_addr, gi ? 32'h400 : 32'h3000);
      e_cf++;
      if (gi) begin
        e_if++;
        st = 0;
      end else begin
        e_ls++;
        st = (st < 4) ? st + 1 : 4;
      end
      @(negedge clk);
      rsp_on(32'h1000 + i, !gi);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    clr_req();
    #1;
    chk_perf("t4");

    // 5: store held off by memory
    @(negedge clk);
    mem_req_ready = 1'b0;
    ls_req_valid  = 1'b1;
    ls_req_we     = 1'b1;
    ls_req_wstrb  = 4'b0011;
    ls_req_addr   = 32'h2004;
    ls_req_wdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_req_ready = 1'b1;
      #1;
      chk("t5_mv", mem_req_valid, 1);
      chk("t5_lsrdy", ls_req_ready, (i == 2) ? 1 : 0);
      chk("t5_addr", mem_req_addr, 32'h2004);
      chk("t5_we", mem_req_we, 1);
      chk("t5_strb", mem_req_wstrb, 4'b0011);
      chk("t5_wd", mem_req_wdata, 32'hDEAD_BEEF);
      if (i < 2) @(negedge clk);
    end
    e_ls++;
    @(negedge clk);
    clr_req();
    rsp_on(32'h55, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("t5_lsv", ls_rsp_valid, 1);
    chk_perf("t5");

    // 6: reset while waiting, then a late response
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h300;
    @(negedge clk);
    clr_req();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    e_if = 0;
    e_ls = 0;
    e_cf = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk_perf("t6");
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h77;
    #1;
    chk("t6_mv", mem_req_valid, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("t6_ifv", if_rsp_valid, 0);
    chk("t6_busy1", busy, 0);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h304;
    #1;
    chk("t6_ifrdy", if_req_ready, 1);
    chk("t6_addr", mem_req_addr, 32'h304);
    e_if++;
    @(negedge clk);
    clr_req();
    rsp_on(32'h99, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("t6_ifv1", if_rsp_valid, 1);
    chk_perf("t6b");

    repeat (2) @(negedge clk);
    chk("if_q_left", if_q.size(), 0);
    chk("ls_q_left", ls_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (LS, MEM stage).
- Sits between those two requesters and the memory; load data it returns reaches MEM_WB through the mem_data path.
- Allows one outstanding transaction at a time, with fixed LS priority and an anti-starvation counter for IF.
- Routes each memory response back to the requester that issued it, as a registered one-cycle pulse.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte strobe width is DATA_W/8
STARVE_MAX, 4, consecutive LS grants allowed while IF waits (range 1..15)

Ports:
clk  in  1  system clock (the design's only clock)
rst  in  1  reset; synchronous and active-low
if_req_valid  in  1  fetch request
if_req_addr  in  ADDR_W  fetch address
if_req_ready  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
if_rsp_data  out  DATA_W  fetch data
ls_req_valid  in  1  load/store request
ls_req_we  in  1  1 = store
ls_req_wstrb  in  DATA_W/8  store byte strobes
ls_req_addr  in  ADDR_W  load/store address
ls_req_wdata  in  DATA_W  store data
ls_req_ready  out  1  load/store request accepted this cycle
ls_rsp_valid  out  1  load data / store ack (1-cycle pulse)
ls_rsp_data  out  DATA_W  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  store
mem_req_wstrb  out  DATA_W/8  byte strobes
mem_req_addr  out  ADDR_W  address
mem_req_wdata  out  DATA_W  write data
mem_rsp_valid  in  1  memory response (loads, fetches and store acks)
mem_rsp_data  in  DATA_W  response data
busy  out  1  transaction outstanding
perf_if_grants  out  32  IF grant count (feature)
perf_ls_grants  out  32  LS grant count (feature)
perf_conflict_cycles  out  32  cycles with both requests valid in IDLE (feature)

Behaviour:
- Reset: rst sampled low at posedge forces the following state.
  - state = IDLE; owner = IF; starve_cnt = 0.
  - if_rsp_valid = ls_rsp_valid = 0; if_rsp_data = ls_rsp_data = 0; busy = 0; all perf counters = 0.
  - Combinational outputs are therefore 0 while in reset (mem_req_valid, both readies).
- FSM states: IDLE and WAIT_RSP.
- IDLE, grant selection (combinational):
  - grant_if = if_req_valid && (!ls_req_valid || starve_cnt == STARVE_MAX).
  - Otherwise LS is granted if ls_req_valid.
- IDLE, memory request:
  - mem_req_valid = if_req_valid || ls_req_valid.
  - mem_req_* is muxed combinationally from the granted requester.
  - For IF grants: mem_req_we = 0, mem_req_wstrb = 0, mem_req_wdata = 0.
  - Granted requester's ready = mem_req_ready; the other ready = 0.
- Acceptance (mem_req_valid && mem_req_ready):
  - Latch owner; go to WAIT_RSP; busy = 1 from the next cycle.
  - starve_cnt: reset to 0 on an IF grant or whenever if_req_valid = 0; increment (saturating at STARVE_MAX) on an LS grant while if_req_valid = 1.
- WAIT_RSP:
  - mem_req_valid = 0; both readies = 0.
  - On mem_rsp_valid: register mem_rsp_data into the owner's rsp_data, pulse the owner's rsp_valid for exactly one cycle (next cycle), return to IDLE.
  - A new request may be accepted in the same cycle the rsp pulse is visible.
  - Minimum turnaround: request accepted cycle N, mem_rsp_valid at N+1, rsp pulse at N+2, next acceptance at N+2.
- Stores wait for mem_rsp_valid as an ack; ls_rsp_data is updated with mem_rsp_data, and its value is don't-care for stores.
- Unowned rsp_data holds its last value.
- mem_rsp_valid while in IDLE is ignored: no pulse, no state change.
- Requesters hold req fields stable while valid && !ready. The arbiter does not re-arbitrate within a cycle and does not latch request fields.
- Reset mid-WAIT_RSP: transaction dropped; a late mem_rsp_valid afterwards is ignored per the IDLE rule.
- Simultaneous if/ls valid with starve_cnt < STARVE_MAX: LS wins.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - perf_if_grants / perf_ls_grants increment on each accepted IF / LS request.
  - perf_conflict_cycles increments each IDLE cycle with both valids high.
  - All three wrap modulo 2^32 and are cleared by reset.
- Undefined: the three ports are constant 0, with no counter flops.

Test Plan:
1. Hold rst low 3 cycles with random inputs -> all outputs 0, busy 0, mem_rsp_valid pulses ignored.
2. IF-only: if_req_addr 0x00000100, memory returns 0x00000013 one cycle after acceptance -> mem_req_addr 0x100, we 0; if_rsp_valid for 1 cycle with data 0x13, two cycles after acceptance; ls_rsp_valid stays 0.
3. Both valid same cycle (IF 0x104, LS load 0x2000) -> first mem_req_addr 0x2000, ls_rsp_valid first; IF granted next with addr 0x104; perf_conflict_cycles = 1 with MEM_ARB_PERF_EN.
4. Starvation (STARVE_MAX = 4): LS and IF continuously valid -> grant order LS, LS, LS, LS, IF, LS...; starve_cnt returns to 0 after the IF grant.
5. Store: ls we 1, wstrb 4'b0011, addr 0x2004, wdata 0xDEADBEEF, mem_req_ready low 2 cycles -> ls_req_ready low until memory ready, mem fields stable and matching; ls_rsp_valid pulses once after the ack.
6. Reset asserted in WAIT_RSP, mem_rsp_valid arrives 1 cycle after reset release -> no rsp pulse, state IDLE, perf counters 0; a subsequent IF request completes normally.
